// File: rtl/btn_pkg.sv
// Shared types and default parameters for the button debounce front end.
package btn_pkg;

  // Debounce FSM state
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONFIRM_HI = 2'd1,
    HELD       = 2'd2,
    CONFIRM_LO = 2'd3
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_PERIOD   = 8;
  localparam bit DEF_REPEAT_EN       = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Shift the raw input through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/btn_debounce_step.sv
// Push-button debounce with press/release/auto-repeat pulses; step feeds the
// count-enable of the downstream mod-8 counter.
module btn_debounce_step
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step
);

  localparam int SW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [SW-1:0] STAB_ONE = SW'(1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] REP_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_PER  = RW'(REPEAT_PERIOD);

  logic s;

  btn_state_e    state_q, state_d;
  logic [SW-1:0] stab_q, stab_d, stab_nxt;
  logic [RW-1:0] rep_q, rep_d, rep_inc, rep_tgt;
  logic          first_q, first_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic          step_q, step_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );

  // Next state, counters and pulses; the confirm counter saturates at
  // DEBOUNCE_CYCLES, and the sample that brings it there completes the change.
  // With DEBOUNCE_CYCLES=1 the entry value is already at the limit, so the
  // first stable sample inside the CONFIRM state completes it.
  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    rep_d     = rep_q;
    first_d   = first_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    stab_nxt  = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_ONE;
    rep_inc   = rep_q + RW'(1);
    rep_tgt   = first_q ? REP_DLY : REP_PER;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = CONFIRM_HI;
          stab_d  = STAB_ONE;
        end
      end
      CONFIRM_HI: begin
        if (!s) begin
          state_d = IDLE;
          stab_d  = '0;
        end else if (stab_nxt == STAB_MAX) begin
          state_d = HELD;
          stab_d  = '0;
          press_d = 1'b1;
          level_d = 1'b1;
          rep_d   = '0;
          first_d = 1'b1;
        end else begin
          stab_d = stab_nxt;
        end
      end
      HELD: begin
        // Repeat timer runs every cycle spent in HELD; first interval is the
        // delay, later ones the period.
        if (rep_inc == rep_tgt) begin
          rep_d    = '0;
          first_d  = 1'b0;
          repeat_d = REPEAT_EN;
        end else begin
          rep_d = rep_inc;
        end
        if (!s) begin
          state_d = CONFIRM_LO;
          stab_d  = STAB_ONE;
        end
      end
      CONFIRM_LO: begin
        // Repeat timer frozen here; a bounce back high resumes it
        if (s) begin
          state_d = HELD;
          stab_d  = '0;
        end else if (stab_nxt == STAB_MAX) begin
          state_d   = IDLE;
          stab_d    = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          stab_d = stab_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        stab_d  = '0;
      end
    endcase

    step_d = press_d | repeat_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      stab_q    <= '0;
      rep_q     <= '0;
      first_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      rep_q     <= rep_d;
      first_q   <= first_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step          = step_q;

endmodule

// File: tb/tb_btn_debounce_step.sv
// Bench for btn_debounce_step: directed test-plan phases plus random button
// activity, every cycle compared against a run-length/schedule model.
module tb_btn_debounce_step;

  localparam int D   = 4;
  localparam int DLY = 16;
  localparam int PER = 8;
  localparam int N   = (D < 2) ? 2 : D;  // stable samples to flip the level

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic lvl_a, prs_a, rel_a, rep_a, stp_a;
  logic lvl_b, prs_b, rel_b, rep_b, stp_b;

  always #5 clk = ~clk;

  btn_debounce_step dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a),
    .repeat_pulse(rep_a), .step(stp_a)
  );

  btn_debounce_step #(.REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b),
    .repeat_pulse(rep_b), .step(stp_b)
  );

  int vec = 0, errs = 0;
  int edge_no = 0;

  // model: b1/b2 = raw samples one and two edges back (2-cycle input latency)
  bit b1, b2, m_lvl, e_prs, e_rel, e_rep;
  int run, act;

  // observed pulse bookkeeping for directed checks
  int n_prs = 0, n_rel = 0, n_rep = 0, n_stp = 0, n_prs_nr = 0, n_rep_nr = 0;
  int prs_edge = 0, rep1_edge = 0, rep_since = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s edge %0d observed %b expected %b", tag, edge_no, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit b, input bit r);
    bit s;
    @(negedge clk);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    edge_no++;
    e_prs = 0; e_rel = 0; e_rep = 0;
    if (r) begin
      b1 = 0; b2 = 0; m_lvl = 0; run = 0; act = 0;
    end else begin
      s = b2; b2 = b1; b1 = b;
      if (!m_lvl) begin
        run = s ? run + 1 : 0;
        if (run == N) begin m_lvl = 1; e_prs = 1; run = 0; act = 0; end
      end else begin
        // hold time accrues only while no candidate release is pending
        if (run == 0) begin
          act++;
          if (act >= DLY && (act - DLY) % PER == 0) e_rep = 1;
        end
        run = s ? 0 : run + 1;
        if (run == N) begin m_lvl = 0; e_rel = 1; run = 0; end
      end
    end
    #1;
    vec++;
    chk("level", lvl_a, m_lvl);
    chk("press", prs_a, e_prs);
    chk("release", rel_a, e_rel);
    chk("repeat", rep_a, e_rep);
    chk("step", stp_a, e_prs | e_rep);
    chk("nr_level", lvl_b, m_lvl);
    chk("nr_press", prs_b, e_prs);
    chk("nr_release", rel_b, e_rel);
    chk("nr_repeat", rep_b, 1'b0);
    chk("nr_step", stp_b, e_prs);
    if (prs_a) begin n_prs++; prs_edge = edge_no; rep_since = 0; end
    if (rel_a) n_rel++;
    if (rep_a) begin
      if (rep_since == 0) rep1_edge = edge_no;
      rep_since++;
      n_rep++;
    end
    if (stp_a) n_stp++;
    if (prs_b) n_prs_nr++;
    if (rep_b) n_rep_nr++;
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b0);
  endtask

  initial begin
    int mark, p0, r0, q0, s0, np0, nq0;

    // reset and idle
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    hold(1'b0, 5);

    // clean press with auto-repeat
    mark = edge_no + 1; p0 = n_prs; q0 = n_rep; s0 = n_stp;
    hold(1'b1, 40);
    chk_int("clean_press_count", n_prs - p0, 1);
    chk_int("clean_press_latency", prs_edge - mark, 5);
    chk("clean_level_high", lvl_a, 1'b1);
    chk_int("repeat_count", n_rep - q0, 3);
    chk_int("repeat_first_delay", rep1_edge - prs_edge, DLY);
    chk_int("step_count", n_stp - s0, 4);

    r0 = n_rel;
    hold(1'b0, 10);
    chk_int("release_count", n_rel - r0, 1);

    // bounce rejection then a stable press
    p0 = n_prs;
    for (int k = 0; k < 5; k++) begin hold(1'b1, 3); hold(1'b0, 1); end
    chk_int("bounce_no_press", n_prs - p0, 0);
    chk("bounce_level_low", lvl_a, 1'b0);
    mark = edge_no + 1;
    hold(1'b1, 20);
    chk_int("bounce_then_press", n_prs - p0, 1);
    chk_int("bounce_press_latency", prs_edge - mark, 5);

    // short low glitch during hold, then real release
    r0 = n_rel;
    hold(1'b0, 2);
    hold(1'b1, 20);
    chk_int("glitch_no_release", n_rel - r0, 0);
    hold(1'b0, 10);
    chk_int("final_release", n_rel - r0, 1);
    chk("final_level_low", lvl_a, 1'b0);
    hold(1'b0, 5);

    // reset during CONFIRM_HI with button still held
    p0 = n_prs;
    hold(1'b1, 5);
    cyc(1'b1, 1'b1);
    chk_int("reset_no_press", n_prs - p0, 0);
    mark = edge_no + 1;
    hold(1'b1, 10);
    chk_int("post_reset_press", n_prs - p0, 1);
    chk_int("post_reset_latency", prs_edge - mark, 5);
    hold(1'b0, 10);

    // long hold: repeat-disabled instance gives one press, no repeats
    np0 = n_prs_nr; nq0 = n_rep_nr; q0 = n_rep;
    hold(1'b1, 100);
    chk_int("nr_press_count", n_prs_nr - np0, 1);
    chk_int("nr_repeat_count", n_rep_nr - nq0, 0);
    chk_int("long_hold_repeats", n_rep - q0, 10);
    hold(1'b0, 10);

    // random button activity with occasional reset
    for (int k = 0; k < 400; k++) begin
      bit b;
      int len;
      b = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
      if ($urandom_range(0, 60) == 0) cyc(b, 1'b1);
      hold(b, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/btn_debounce_step.md
# btn_debounce_step

Debounce and auto-repeat front end for a push-button. Takes a raw, asynchronous, bouncy button input and produces a clean debounced level plus single-cycle press, release and auto-repeat pulses. Its `step` output drives the count-enable of the downstream mod-8 counter stage (`count_mod8`), giving one count per press and repeated counts while the button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a level change; legal range ≥1.
- `REPEAT_DELAY`, default 16: cycles from `press_pulse` to the first `repeat_pulse`; legal range ≥1.
- `REPEAT_PERIOD`, default 8: cycles between subsequent `repeat_pulse`s; legal range ≥1.
- `REPEAT_EN`, default 1: 0 disables auto-repeat entirely.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `btn_in` input, 1 bit: raw button, asynchronous to `clk`, active-high.
- `btn_level` output, 1 bit: debounced button level.
- `press_pulse` output, 1 bit: one-cycle pulse on an accepted press.
- `release_pulse` output, 1 bit: one-cycle pulse on an accepted release.
- `repeat_pulse` output, 1 bit: one-cycle auto-repeat pulse while held.
- `step` output, 1 bit: `press_pulse | repeat_pulse`; count-enable for the downstream counter.

## Operation
- **Input synchronizer:** `btn_in` passes through a 2-flop synchronizer; both flops reset to 0. The FSM sees only the synchronized signal, `s`.
- **FSM states:**
  - `IDLE`: debounced low.
  - `CONFIRM_HI`: candidate press.
  - `HELD`: debounced high.
  - `CONFIRM_LO`: candidate release.
- **Transitions:**
  - `IDLE`, `s`=1 → `CONFIRM_HI`, with `stab_cnt`=1.
  - `CONFIRM_HI`, `s`=0 → `IDLE`, `stab_cnt` cleared, no pulse (glitch rejected).
  - `CONFIRM_HI`, `s`=1 and `stab_cnt`=`DEBOUNCE_CYCLES` → `HELD`. Assert `press_pulse`, set `btn_level`=1, clear `rep_cnt`.
  - `HELD`, `s`=0 → `CONFIRM_LO`, with `stab_cnt`=1.
  - `CONFIRM_LO`, `s`=1 → `HELD`. `rep_cnt` is preserved, not reset.
  - `CONFIRM_LO`, `s`=0 and `stab_cnt`=`DEBOUNCE_CYCLES` → `IDLE`. Assert `release_pulse`, set `btn_level`=0.
  - `DEBOUNCE_CYCLES`=1 is a special case: the first stable sample after entering a CONFIRM state completes the transition.
- **Auto-repeat:**
  - `rep_cnt` increments only in `HELD` and freezes in `CONFIRM_LO`.
  - `repeat_pulse` fires when `rep_cnt` reaches `REPEAT_DELAY`. After that, `rep_cnt` reloads and fires every `REPEAT_PERIOD` cycles.
  - No repeat pulse is issued in the same cycle as `press_pulse`.
  - `REPEAT_EN`=0 forces `repeat_pulse` to 0.
- **Pulse rules:** `press_pulse`, `release_pulse` and `repeat_pulse` are mutually exclusive and each lasts exactly one cycle.
- **Counter widths:**
  - `stab_cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - `rep_cnt` is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)` bits.
  - Neither counter wraps: each saturates or is cleared by a state transition.
- **Reset:**
  - State returns to `IDLE`; all counters and synchronizer flops clear.
  - All outputs are 0 in the cycle after the reset edge.
  - Reset mid-press discards progress with no pulse emitted.
  - A button held through reset deassertion produces a fresh `press_pulse` after the full latency.

## Timing
- All outputs are registered; none is combinational from `btn_in`.
- Let edge 1 be the first `clk` edge sampling `btn_in`=1 with the input stable thereafter. `press_pulse` and `btn_level` rise after edge 2+`DEBOUNCE_CYCLES`. With default parameters this is edge 6.
- Release latency mirrors press latency: `release_pulse` rises after edge 2+`DEBOUNCE_CYCLES`, counted from the first sampled 0.
- If `press_pulse` is high in cycle P, `repeat_pulse` is high in cycles P+`REPEAT_DELAY`, then P+`REPEAT_DELAY`+k·`REPEAT_PERIOD`. This assumes no `CONFIRM_LO` excursions; each excursion shifts the schedule by its length.
- `step` equals `press_pulse | repeat_pulse` in the same cycle.
- An input pulse of any width up to `DEBOUNCE_CYCLES`−1 cycles has no effect, provided it is synchronously stable.

## Structure
- Shared package `btn_pkg` holds:
  - the FSM state typedef (`IDLE`, `CONFIRM_HI`, `HELD`, `CONFIRM_LO`, 2-bit encoding);
  - the default parameter constants.
- One natural sub-module, `sync_2ff`: a 2-flop synchronizer with ports `clk`, `rst`, `d`, `q`, reset to 0. It is reusable by other asynchronous inputs.
- The FSM, counters and pulse logic live in `btn_debounce_step` itself.

## Test plan
All scenarios use default parameters.
- **Clean press:** `btn_in` 0→1 held for 40 cycles → `press_pulse` exactly once after edge 6, `btn_level`=1 from then on.
- **Auto-repeat:** `press_pulse` at cycle P, button held → `repeat_pulse` at P+16, P+24 and P+32; `step` is high on all four cycles and never high otherwise.
- **Bounce rejection:** `btn_in` toggled high 3 cycles, low 1 cycle, repeated 5 times → no `press_pulse`, `btn_level` stays 0. A following stable high → a single press at the full latency.
- **Release and glitch during hold:** hold for 20 cycles, then low for 2 cycles, then high again → no `release_pulse`, `rep_cnt` frozen during the excursion. A final low for 10 cycles → `release_pulse` once, `btn_level` falls.
- **Reset mid-confirm:** assert `rst` at the 3rd cycle of `CONFIRM_HI` → no pulse, all outputs 0. With the button still held after reset → `press_pulse` 6 edges after reset deassertion.
- **Repeat disabled:** `REPEAT_EN`=0, hold for 100 cycles → exactly one `press_pulse` and zero `repeat_pulse`.
